// File: rtl/letter_writer_grid.sv
`default_nettype none
// ============================================================================
// letter_writer_grid : renders a NUM_LINES x CHARS_PER_LINE text grid via a
// 1-cycle font ROM; optional macro LW_HIGHLIGHT_EN inverts one line.  Rev 1.0
// ============================================================================
module letter_writer_grid #(
    parameter int NUM_LINES      = 12,
    parameter int CHARS_PER_LINE = 9,
    parameter int CHAR_BITS      = 7,
    parameter int GLYPH_W        = 8,
    parameter int GLYPH_H        = 16,
    parameter int X0             = 65,
    parameter int Y0             = 72,
    parameter int LINE_PITCH     = 40
) (
    input  logic                                          CLK,
    input  logic                                          RESET_N,
    input  logic [10:0]                                   H_counter,
    input  logic [9:0]                                    ve_counter,
    input  logic [NUM_LINES*CHARS_PER_LINE*CHAR_BITS-1:0] words,
    output logic [CHAR_BITS+$clog2(GLYPH_H)-1:0]          rom_addr,
    input  logic [GLYPH_W-1:0]                            rom_data,
    input  logic [3:0]                                    hl_line,
    output logic                                          pixel_out,
    output logic                                          pixel_valid,
    output logic [3:0]                                    line_idx,
    output logic [3:0]                                    char_idx
);

    localparam int C_ROW_W  = $clog2(GLYPH_H);
    localparam int C_BIT_W  = $clog2(GLYPH_W);
    localparam int C_CHAR_W = $clog2(CHARS_PER_LINE + 1);
    localparam int C_ADDR_W = CHAR_BITS + C_ROW_W;
    localparam int C_TOTAL  = NUM_LINES * CHARS_PER_LINE;
    localparam int C_X_LAST = X0 + CHARS_PER_LINE * GLYPH_W - 1;

    logic                 armed_q,    armed_d;
    logic [C_BIT_W-1:0]   bit_cnt_q,  bit_cnt_d;
    logic [C_CHAR_W-1:0]  char_cnt_q, char_cnt_d;
    logic                 valid1_q,   valid1_d;
    logic [C_BIT_W-1:0]   bit1_q,     bit1_d;
    logic [3:0]           line1_q,    line1_d;
    logic [C_CHAR_W-1:0]  char1_q,    char1_d;
    logic [C_ADDR_W-1:0]  rom_addr_q, rom_addr_d;
    logic                 valid2_q,   valid2_d;
    logic [C_BIT_W-1:0]   bit2_q,     bit2_d;
    logic [3:0]           line2_q,    line2_d;
    logic [3:0]           char2_q,    char2_d;

    logic                 v_act;
    logic                 h_act;
    logic                 at_x0;
    logic                 active;
    logic [3:0]           line_sel;
    logic [C_ROW_W-1:0]   row_sel;
    logic [C_BIT_W-1:0]   bit_eff;
    logic [C_CHAR_W-1:0]  char_eff;
    logic [31:0]          fetch_lsb;
    logic [CHAR_BITS-1:0] code;
    logic                 glyph_bit;
    logic                 raw_pixel;

    // Vertical decode: find the line whose glyph rows contain ve_counter.
    always_comb begin
        logic [31:0] v_i;
        logic [31:0] base;
        v_i      = {22'd0, ve_counter};
        base     = '0;
        v_act    = 1'b0;
        line_sel = '0;
        row_sel  = '0;
        for (int k = 0; k < NUM_LINES; k++) begin
            base = 32'(Y0 + k * LINE_PITCH);
            if (v_i >= base && v_i < base + 32'(GLYPH_H)) begin
                v_act    = 1'b1;
                line_sel = 4'(k);
                row_sel  = C_ROW_W'(v_i - base);
            end
        end
    end

    // Stage 0: glyph column / character counters, restarted at H_counter==X0.
    // armed_q stops stale counts from rendering after a mid-line reset.
    always_comb begin
        at_x0      = (H_counter == 11'(X0));
        h_act      = ({21'd0, H_counter} >= 32'(X0)) && ({21'd0, H_counter} <= 32'(C_X_LAST));
        bit_eff    = at_x0 ? '0 : bit_cnt_q;
        char_eff   = at_x0 ? '0 : char_cnt_q;
        active     = v_act && h_act && (armed_q || at_x0);
        armed_d    = armed_q || at_x0;
        bit_cnt_d  = bit_eff;
        char_cnt_d = char_eff;
        if (active) begin
            if (bit_eff == C_BIT_W'(GLYPH_W - 1)) begin
                bit_cnt_d  = '0;
                char_cnt_d = char_eff + C_CHAR_W'(1);
            end else begin
                bit_cnt_d  = bit_eff + C_BIT_W'(1);
            end
        end
    end

    // Stage 1: fetch the character code and issue the ROM address.
    always_comb begin
        fetch_lsb  = (32'(C_TOTAL - 1) - ({28'd0, line_sel} * 32'(CHARS_PER_LINE)
                     + 32'(char_eff))) * 32'(CHAR_BITS);
        code       = CHAR_BITS'(words >> fetch_lsb);
        valid1_d   = active;
        bit1_d     = bit_eff;
        line1_d    = line_sel;
        char1_d    = char_eff;
        rom_addr_d = active ? {code, row_sel} : rom_addr_q;
        valid2_d   = valid1_q;
        bit2_d     = bit1_q;
        line2_d    = line1_q;
        char2_d    = 4'(char1_q);
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            armed_q    <= 1'b0;
            bit_cnt_q  <= '0;
            char_cnt_q <= '0;
            valid1_q   <= 1'b0;
            bit1_q     <= '0;
            line1_q    <= '0;
            char1_q    <= '0;
            rom_addr_q <= '0;
            valid2_q   <= 1'b0;
            bit2_q     <= '0;
            line2_q    <= '0;
            char2_q    <= '0;
        end else begin
            armed_q    <= armed_d;
            bit_cnt_q  <= bit_cnt_d;
            char_cnt_q <= char_cnt_d;
            valid1_q   <= valid1_d;
            bit1_q     <= bit1_d;
            line1_q    <= line1_d;
            char1_q    <= char1_d;
            rom_addr_q <= rom_addr_d;
            valid2_q   <= valid2_d;
            bit2_q     <= bit2_d;
            line2_q    <= line2_d;
            char2_q    <= char2_d;
        end
    end

    // Stage 2: rom_data arrives here, aligned with the stage-2 registers.
    assign glyph_bit   = rom_data[C_BIT_W'(GLYPH_W - 1) - bit2_q];
    assign raw_pixel   = glyph_bit & valid2_q;
    assign rom_addr    = rom_addr_q;
    assign pixel_valid = valid2_q;
    assign line_idx    = line2_q;
    assign char_idx    = char2_q;

`ifdef LW_HIGHLIGHT_EN
    assign pixel_out = raw_pixel ^ (valid2_q && (line2_q == hl_line));
`else
    logic unused_hl;
    assign unused_hl = ^hl_line;
    assign pixel_out = raw_pixel;
`endif

endmodule
`default_nettype wire

// File: tb/tb_letter_writer_grid.sv
`default_nettype none
// ============================================================================
// tb_letter_writer_grid : randomized sweeps checked against an arithmetic
// reference model of the text grid and font ROM.  Rev 1.0
// ============================================================================
module tb_letter_writer_grid;

    localparam int NL    = 12;
    localparam int CPL   = 9;
    localparam int CB    = 7;
    localparam int GW    = 8;
    localparam int GH    = 16;
    localparam int X0    = 65;
    localparam int Y0    = 72;
    localparam int LP    = 40;
    localparam int AW    = CB + 4;
    localparam int WW    = NL * CPL * CB;
    localparam int X_END = X0 + CPL * GW - 1;
    localparam int MAXS  = 4096;

    logic          CLK = 1'b0;
    logic          RESET_N = 1'b0;
    logic [10:0]   H_counter = '0;
    logic [9:0]    ve_counter = '0;
    logic [WW-1:0] words = '0;
    logic [AW-1:0] rom_addr;
    logic [GW-1:0] rom_data = '0;
    logic [3:0]    hl_line = 4'd15;
    logic          pixel_out;
    logic          pixel_valid;
    logic [3:0]    line_idx;
    logic [3:0]    char_idx;

    always #5 CLK = ~CLK;

    letter_writer_grid dut (
        .CLK         (CLK),
        .RESET_N     (RESET_N),
        .H_counter   (H_counter),
        .ve_counter  (ve_counter),
        .words       (words),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .hl_line     (hl_line),
        .pixel_out   (pixel_out),
        .pixel_valid (pixel_valid),
        .line_idx    (line_idx),
        .char_idx    (char_idx)
    );

    logic [GW-1:0] font [0:(1<<AW)-1];
    always @(posedge CLK) rom_data <= font[rom_addr];

    logic [CB-1:0] text [NL][CPL];

    int            n_checks = 0;
    int            n_fail   = 0;
    int            n_step   = 0;
    bit            armed    = 0;
    logic [AW-1:0] last_addr = '0;
    bit            exp_pv   [MAXS];
    bit            exp_po   [MAXS];
    int            exp_line [MAXS];
    int            exp_char [MAXS];
    logic [AW-1:0] exp_addr [MAXS];

    task automatic chk(input string tag, input int got, input int want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s step %0d: got %0d expected %0d", tag, n_step, got, want);
        end
    endtask

    function automatic logic [WW-1:0] pack();
        logic [WW-1:0] w = '0;
        for (int l = 0; l < NL; l++)
            for (int c = 0; c < CPL; c++)
                w = (w << CB) | WW'(text[l][c]);
        return w;
    endfunction

    // Reference: position within the grid from plain division of the sweep.
    function automatic void model(input int n, input int h, input int v, input bit rstn);
        int            i;
        int            k;
        int            row;
        int            c;
        int            b;
        logic [GW-1:0] g;
        i = n % MAXS;
        exp_pv[i] = 0;
        exp_po[i] = 0;
        if (!rstn) begin
            armed     = 0;
            last_addr = '0;
            exp_addr[i] = '0;
            if (n >= 1) begin
                exp_pv[(n-1) % MAXS] = 0;
                exp_po[(n-1) % MAXS] = 0;
            end
            return;
        end
        if (h == X0) armed = 1;
        if (armed && v >= Y0 && h >= X0 && h <= X_END) begin
            k   = (v - Y0) / LP;
            row = (v - Y0) % LP;
            if (k < NL && row < GH) begin
                c = (h - X0) / GW;
                b = (h - X0) % GW;
                last_addr = {text[k][c], 4'(row)};
                g = font[last_addr];
                exp_pv[i] = 1;
                exp_po[i] = g[GW-1-b];
`ifdef LW_HIGHLIGHT_EN
                if (k == int'(hl_line)) exp_po[i] = ~exp_po[i];
`endif
                exp_line[i] = k;
                exp_char[i] = c;
            end
        end
        exp_addr[i] = last_addr;
    endfunction

    task automatic step(input int h, input int v, input bit rstn, input bit mutate);
        int j;
        @(negedge CLK);
        if (n_step >= 1)
            chk("rom_addr", int'(rom_addr), int'(exp_addr[(n_step-1) % MAXS]));
        if (n_step >= 2) begin
            j = (n_step - 2) % MAXS;
            chk("pixel_valid", int'(pixel_valid), int'(exp_pv[j]));
            chk("pixel_out", int'(pixel_out), int'(exp_po[j]));
            if (exp_pv[j]) begin
                chk("line_idx", int'(line_idx), exp_line[j]);
                chk("char_idx", int'(char_idx), exp_char[j]);
            end
        end
        if (mutate) begin
            text[$urandom_range(0, NL-1)][$urandom_range(0, CPL-1)] = CB'($urandom);
            words = pack();
        end
        H_counter  = 11'(h);
        ve_counter = 10'(v);
        RESET_N    = rstn;
        model(n_step, h, v, rstn);
        n_step++;
    endtask

    // Two idle cycles flush the previous sweep before hl_line may change.
    task automatic sweep(input int v, input int hs, input int he, input int rst_h,
                         input int hl, input bit mut);
        step(1500, v, 1'b1, 1'b0);
        step(1500, v, 1'b1, 1'b0);
        hl_line = 4'(hl);
        for (int h = hs; h <= he; h++)
            step(h, v, (h != rst_h), mut && ($urandom_range(0, 15) == 0));
    endtask

    initial begin
        int k;
        int v;
        int hs;
        int he;
        int rh;
        for (int a = 0; a < (1 << AW); a++) font[a] = GW'($urandom);
        for (int c = 0; c < (1 << CB); c++) font[AW'(c * GH)] = 8'hA5;
        for (int l = 0; l < NL; l++)
            for (int c = 0; c < CPL; c++)
                text[l][c] = CB'($urandom);
        words = pack();

        repeat (3) step(0, 0, 1'b0, 1'b0);
        chk("rst pixel_out", int'(pixel_out), 0);
        chk("rst pixel_valid", int'(pixel_valid), 0);
        chk("rst rom_addr", int'(rom_addr), 0);
        chk("rst line_idx", int'(line_idx), 0);
        chk("rst char_idx", int'(char_idx), 0);

        sweep(72, 60, 140, -1, 15, 1'b0);
        sweep(88, 60, 140, -1, 15, 1'b0);
        sweep(527, 60, 137, -1, 15, 1'b0);
        text[3][2] = 7'h41;
        words = pack();
        sweep(192, 60, 100, -1, 15, 1'b0);
        sweep(72, 60, 140, 100, 15, 1'b0);
        sweep(72, 60, 140, -1, 15, 1'b0);
        sweep(72, 60, 140, -1, 0, 1'b0);
        sweep(72, 60, 140, -1, 12, 1'b0);

        repeat (80) begin
            k  = $urandom_range(0, NL);
            v  = Y0 + k * LP + $urandom_range(0, LP - 1);
            hs = $urandom_range(X0 - 6, X0);
            he = $urandom_range(X0 - 1, X_END + 4);
            rh = ($urandom_range(0, 9) == 0) ? $urandom_range(hs, he) : -1;
            sweep(v, hs, he, rh, $urandom_range(0, NL + 1), 1'b1);
        end
        repeat (3) step(1500, 0, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/letter_writer_grid.md
LETTER_WRITER_GRID -- requirements
Module: letter_writer_grid

Interface
REQ-001 Parameter NUM_LINES, default 12, number of text lines drawn.
REQ-002 Parameter CHARS_PER_LINE, default 9, characters per line.
REQ-003 Parameter CHAR_BITS, default 7, character code width.
REQ-004 Parameter GLYPH_W, default 8, glyph width in pixels.
REQ-005 Parameter GLYPH_H, default 16, glyph height in pixels.
REQ-006 Parameter X0, default 65, first active H_counter value of every line.
REQ-007 Parameter Y0, default 72, first active ve_counter value of line 0.
REQ-008 Parameter LINE_PITCH, default 40, ve_counter distance between line starts; must be at least GLYPH_H, otherwise the configuration is illegal.
REQ-009 CLK  input  1  pixel clock; RESET_N  input  1  reset, synchronous, active-low.
REQ-010 H_counter  input  11  horizontal pixel position.
REQ-011 ve_counter  input  10  vertical line position.
REQ-012 words  input  NUM_LINES*CHARS_PER_LINE*CHAR_BITS  packed text; line 0, char 0 occupies the MSBs; order is line-major, then char-major.
REQ-013 rom_addr  output  CHAR_BITS+clog2(GLYPH_H)  font ROM address {code,row}.
REQ-014 rom_data  input  GLYPH_W  font row, valid exactly 1 cycle after rom_addr; MSB is the leftmost pixel.
REQ-015 hl_line  input  4  line index to highlight (used only with the macro).
REQ-016 pixel_out  output  1  rendered pixel; pixel_valid  output  1  pixel_out lies inside a glyph cell.
REQ-017 line_idx  output  4  and char_idx  output  4  cell coordinates aligned with pixel_out.

Function
REQ-018 Line k is vertically active when ve_counter is in [Y0+k*LINE_PITCH, Y0+k*LINE_PITCH+GLYPH_H-1] for k<NUM_LINES; row = ve_counter minus the line base.
REQ-019 Horizontal window: H_counter in [X0, X0+CHARS_PER_LINE*GLYPH_W-1]; a cycle is active when both the vertical and horizontal conditions hold.
REQ-020 Stage 0 (registered): bit_cnt and char_cnt counters.
- Both load 0 when H_counter==X0.
- bit_cnt increments on each active cycle and wraps from GLYPH_W-1 to 0, incrementing char_cnt on the wrap.
- No divider is used.
REQ-021 Stage 1: select the code for (k, char_cnt) from words; drive rom_addr={code,row}; register the valid flag, bit_cnt, k and char_cnt.
REQ-022 Stage 2: pixel_out = rom_data[GLYPH_W-1-bit_cnt] ANDed with the valid flag; pixel_valid, line_idx and char_idx are delayed to align.
REQ-023 Latency: pixel_out corresponds to the H/V values sampled 2 cycles earlier, fixed and independent of parameters.
REQ-024 Inactive cycles:
- pixel_out=0, pixel_valid=0.
- Counters hold, and reload at the next H_counter==X0.
REQ-025 H_counter leaving the window mid-glyph truncates that glyph; no state carries into the next line.
REQ-026 A change to words takes effect on the next stage-1 fetch; there is no shadow copy.
REQ-027 rom_addr holds its last value while inactive.

Reset
REQ-028 While RESET_N=0 at a CLK edge, clear all counters and pipeline valid flags.
REQ-029 Reset values: pixel_out=0, pixel_valid=0, rom_addr=0, line_idx=0, char_idx=0.
REQ-030 Reset mid-frame: outputs are 0 from the first edge with RESET_N=0; rendering resumes at the next H_counter==X0 after release.

Configuration
REQ-031 With macro LW_HIGHLIGHT_EN defined: pixel_out is inverted (pixel_valid unchanged) for every valid pixel of the line whose index equals hl_line; hl_line >= NUM_LINES highlights nothing.
REQ-032 Without LW_HIGHLIGHT_EN: hl_line is ignored and no inversion logic is synthesised.

Verification
REQ-033 Defaults, ve=72, H sweeps 65..136, rom model returns 8'hA5 -> pixel_valid high for 72 cycles starting 2 cycles after H=65; pixel_out repeats 1,0,1,0,0,1,0,1.
REQ-034 ve=88 (gap between lines 0 and 1), any H -> pixel_valid=0, pixel_out=0 throughout.
REQ-035 ve=527 (line 11, row 15), H=137 (one past the window) -> pixel_valid=0 two cycles later; at H=136 -> line_idx=11, char_idx=8, rom_addr row field = 15.
REQ-036 words has line 3, char 2 = 7'h41; ve=192, H=81 -> rom_addr={7'h41,4'd0} one cycle later.
REQ-037 RESET_N=0 for 1 cycle at H=100 -> pixel_out=0 next cycle; no valid pixels until after the next H=65.
REQ-038 With LW_HIGHLIGHT_EN, hl_line=0, rom=8'hFF, ve=72 -> pixel_out=0 across line 0; hl_line=12 -> pixel_out=1.
